// File: rtl/adc_uart_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// adc_uart_frame_sequencer_if
// Groups the UART receive and transmit handshake signals that the frame
// sequencer uses.
//   rx_data[7:0]  command byte from the UART receiver (valid when rx_ready=1)
//   rx_ready      one-cycle strobe from the UART receiver
//   tx_ready      UART transmitter idle; 1 = can accept a byte
//   tx_data[7:0]  byte presented to the UART transmitter
//   tx_en         one-cycle start strobe
//   tx_write_en   one-cycle write strobe, coincident with tx_en
// Modports:
//   master - the sequencer (drives the tx byte and strobes)
//   slave  - the UART side (drives rx_* and tx_ready)
// ---------------------------------------------------------------------------
interface adc_uart_frame_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_en;
  logic       tx_write_en;

  modport master (
    input  rx_data, rx_ready, tx_ready,
    output tx_data, tx_en, tx_write_en
  );

  modport slave (
    output rx_data, rx_ready, tx_ready,
    input  tx_data, tx_en, tx_write_en
  );
endinterface

// File: rtl/adc_uart_frame_sequencer.sv
// ---------------------------------------------------------------------------
// adc_uart_frame_sequencer
// Command-driven transmit scheduler between the four SPI ADC channels and the
// UART transmitter. A command byte ('1'..'4' for one channel, 'A' for all)
// snapshots the ADC channels and serialises a framed packet one byte at a
// time: HEADER, then (id, hi, lo) per selected channel, then optionally an
// XOR checksum of every byte sent.
//
// Build option:
//   FRAME_CHECKSUM_EN  defined   -> trailing XOR checksum byte (5 / 14 bytes)
//                      undefined -> no checksum logic      (4 / 13 bytes)
//
// Parameters:
//   ACK_TIMEOUT  max cycles to wait for tx_ready to fall after a byte issue
//   HEADER       first byte of every frame
// Ports:
//   clk                 system clock, posedge
//   reset_b             asynchronous active-low reset
//   uart                UART rx/tx handshake (master modport)
//   adc_ch1..adc_ch4    live 10-bit channel samples
//   busy                1 from command accept until frame complete/abort
//   cmd_err             1-cycle pulse: invalid command or command while busy
//   tx_timeout          sticky ack-timeout flag, cleared by next accept
// ---------------------------------------------------------------------------
module adc_uart_frame_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 4096,
  parameter logic [7:0]  HEADER      = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_b,
  adc_uart_frame_sequencer_if.master uart,
  input  logic [9:0] adc_ch1,
  input  logic [9:0] adc_ch2,
  input  logic [9:0] adc_ch3,
  input  logic [9:0] adc_ch4,
  output logic       busy,
  output logic       cmd_err,
  output logic       tx_timeout
);

  localparam int unsigned   CW       = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
  typedef enum logic [1:0] {F_ID, F_HI, F_LO} field_t;

  state_t        state, next_state;
  logic [3:0]    byte_idx;
  logic [3:0]    last_idx;
  logic [CW-1:0] ack_cnt;
  logic [9:0]    snap [4];
  logic          all_mode;
  logic [1:0]    sel_ch;

  logic          cmd_valid;
  logic          accept;
  logic          issue;
  logic          abort;
  logic          advance;
  logic          frame_end;

  logic [1:0]    ch_sel;
  field_t        field;
  logic [9:0]    sample;
  logic [7:0]    frame_byte;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0]    cks;
  assign last_idx = all_mode ? 4'd13 : 4'd4;
`else
  assign last_idx = all_mode ? 4'd12 : 4'd3;
`endif

  assign cmd_valid = (uart.rx_data inside {[8'h31:8'h34], 8'h41});
  assign busy      = (state != IDLE);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= next_state;
  end

  // -------------------------------------------------------------------------
  // FSM next-state and per-cycle control decode
  // -------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    abort      = 1'b0;
    advance    = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      IDLE: begin
        if (uart.rx_ready && cmd_valid) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (uart.tx_ready) begin
          issue      = 1'b1;
          next_state = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!uart.tx_ready) begin
          next_state = WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_DONE: begin
        if (uart.tx_ready) begin
          if (byte_idx == last_idx) begin
            frame_end  = 1'b1;
            next_state = IDLE;
          end else begin
            advance    = 1'b1;
            next_state = ISSUE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame byte selection. Byte 0 is the header; bytes 1..12 walk (id, hi, lo)
  // triplets, the channel advancing every three bytes in all-channel mode.
  // -------------------------------------------------------------------------
  always_comb begin
    ch_sel = sel_ch;
    if (all_mode) begin
      case (byte_idx)
        4'd4, 4'd5, 4'd6:    ch_sel = 2'd1;
        4'd7, 4'd8, 4'd9:    ch_sel = 2'd2;
        4'd10, 4'd11, 4'd12: ch_sel = 2'd3;
        default:             ch_sel = 2'd0;
      endcase
    end

    case (byte_idx)
      4'd1, 4'd4, 4'd7, 4'd10: field = F_ID;
      4'd2, 4'd5, 4'd8, 4'd11: field = F_HI;
      default:                 field = F_LO;
    endcase

    sample = snap[ch_sel];

    frame_byte = sample[7:0];
    if (byte_idx == 4'd0) begin
      frame_byte = HEADER;
`ifdef FRAME_CHECKSUM_EN
    end else if (byte_idx == last_idx) begin
      frame_byte = cks;
`endif
    end else if (field == F_ID) begin
      frame_byte = 8'(ch_sel) + 8'd1;
    end else if (field == F_HI) begin
      frame_byte = {6'd0, sample[9:8]};
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: snapshot, byte index, ack timer, strobes and status flags
  // -------------------------------------------------------------------------
  // NOTE: the snapshot registers are reset along with the rest so that a
  // frame byte is never built from uninitialised storage.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < 4; i++) snap[i] <= '0;
      all_mode    <= 1'b0;
      sel_ch      <= 2'd0;
      byte_idx    <= 4'd0;
      ack_cnt     <= '0;
      uart.tx_data     <= 8'h00;
      uart.tx_en       <= 1'b0;
      uart.tx_write_en <= 1'b0;
      cmd_err     <= 1'b0;
      tx_timeout  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      cks         <= 8'h00;
`endif
    end else begin
      // Any received byte that is not accepted (bad code, or FSM not idle)
      // is reported one cycle later and otherwise dropped.
      cmd_err          <= uart.rx_ready && !accept;
      uart.tx_en       <= issue;
      uart.tx_write_en <= issue;

      if (accept) begin
        snap[0]    <= adc_ch1;
        snap[1]    <= adc_ch2;
        snap[2]    <= adc_ch3;
        snap[3]    <= adc_ch4;
        all_mode   <= (uart.rx_data == 8'h41);
        sel_ch     <= uart.rx_data[1:0] - 2'd1;  // '1'..'4' -> 0..3
        tx_timeout <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
        cks        <= 8'h00;
`endif
      end

      if (issue) begin
        uart.tx_data <= frame_byte;
`ifdef FRAME_CHECKSUM_EN
        cks          <= cks ^ frame_byte;
`endif
      end

      if (issue)                   ack_cnt <= '0;
      else if (state == WAIT_ACK)  ack_cnt <= ack_cnt + 1'b1;

      if (frame_end || abort)      byte_idx <= 4'd0;
      else if (advance)            byte_idx <= byte_idx + 4'd1;

      if (abort) tx_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_uart_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adc_uart_frame_sequencer
// Self-checking bench for adc_uart_frame_sequencer. A UART responder drives
// tx_ready, a monitor captures every strobed byte, and expected frames come
// from a byte-list model of the frame format. Honours FRAME_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_adc_uart_frame_sequencer;
  localparam int unsigned ACK_TIMEOUT = 4096;
  localparam logic [7:0]  HEADER      = 8'hA5;
`ifdef FRAME_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_b = 1'b1;
  logic [9:0] adc_ch1, adc_ch2, adc_ch3, adc_ch4;
  logic       busy, cmd_err, tx_timeout;

  adc_uart_frame_sequencer_if u ();

  always #5 clk = ~clk;

  adc_uart_frame_sequencer #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .HEADER      (HEADER)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .uart       (u),
    .adc_ch1    (adc_ch1),
    .adc_ch2    (adc_ch2),
    .adc_ch3    (adc_ch3),
    .adc_ch4    (adc_ch4),
    .busy       (busy),
    .cmd_err    (cmd_err),
    .tx_timeout (tx_timeout)
  );

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         n_strobes = 0;
  logic [7:0] cap[$];
  logic [7:0] exp_q[$];
  bit         stuck     = 1'b0;
  bit         rnd_uart  = 1'b0;
  int         ack_delay = 2;
  int         low_len   = 10;
  logic       prev_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // UART transmitter model: after a strobe, drop tx_ready after a delay and
  // hold it low for a while (the byte "transmitting").
  initial begin
    u.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (u.tx_en && !stuck) begin
        int d, l;
        d = rnd_uart ? int'($urandom_range(0, 3)) : ack_delay;
        l = rnd_uart ? int'($urandom_range(1, 8)) : low_len;
        repeat (d) @(negedge clk);
        u.tx_ready = 1'b0;
        repeat (l) @(negedge clk);
        u.tx_ready = 1'b1;
      end
    end
  end

  // Byte monitor and strobe-shape checks.
  always @(negedge clk) begin
    if (u.tx_en) begin
      cap.push_back(u.tx_data);
      n_strobes++;
      check("strobe_width", prev_en, 0);
      check("write_en", u.tx_write_en, 1);
    end else begin
      if (u.tx_write_en) check("write_en_alone", u.tx_write_en, 0);
      if (busy && cap.size() > 0) check("tx_data_hold", u.tx_data, cap[$]);
    end
    prev_en = u.tx_en;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit is_valid(input logic [7:0] c);
    return (c >= 8'h31 && c <= 8'h34) || c == 8'h41;
  endfunction

  // Reference frame: header, (id, hi, lo) per selected channel, then XOR.
  task automatic model_frame(input logic [7:0] cmd, input logic [9:0] c1, c2, c3, c4);
    logic [9:0] ch [4];
    ch = '{c1, c2, c3, c4};
    exp_q.delete();
    exp_q.push_back(HEADER);
    for (int c = 0; c < 4; c++) begin
      if (cmd == 8'h41 || (int'(cmd) - 32'h31) == c) begin
        exp_q.push_back(8'(c + 1));
        exp_q.push_back({6'd0, ch[c][9:8]});
        exp_q.push_back(ch[c][7:0]);
      end
    end
`ifdef FRAME_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
    end
`endif
  endtask

  task automatic send_cmd(input logic [7:0] b, output logic err);
    u.rx_data  = b;
    u.rx_ready = 1'b1;
    @(negedge clk);
    u.rx_ready = 1'b0;
    err = cmd_err;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic compare_frame(input string name);
    check({name, "_len"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_b%0d", name, i), (i < cap.size()) ? cap[i] : 8'hxx, exp_q[i]);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_tx_data"},     u.tx_data, 8'h00);
    check({name, "_tx_en"},       u.tx_en, 0);
    check({name, "_tx_write_en"}, u.tx_write_en, 0);
    check({name, "_busy"},        busy, 0);
    check({name, "_cmd_err"},     cmd_err, 0);
    check({name, "_tx_timeout"},  tx_timeout, 0);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic       exp_err;
    int         exp_len;
  } vec_t;

  initial begin
    vec_t       vecs [12];
    logic       err;
    int         n0, k;
    logic [7:0] c;
    logic [7:0] vc [5];

    vecs[0]  = '{8'h31, 1'b0, 4 + CK};
    vecs[1]  = '{8'h32, 1'b0, 4 + CK};
    vecs[2]  = '{8'h33, 1'b0, 4 + CK};
    vecs[3]  = '{8'h34, 1'b0, 4 + CK};
    vecs[4]  = '{8'h41, 1'b0, 13 + CK};
    vecs[5]  = '{8'h35, 1'b1, 0};
    vecs[6]  = '{8'h30, 1'b1, 0};
    vecs[7]  = '{8'h00, 1'b1, 0};
    vecs[8]  = '{8'h61, 1'b1, 0};
    vecs[9]  = '{8'h40, 1'b1, 0};
    vecs[10] = '{8'h42, 1'b1, 0};
    vecs[11] = '{8'hFF, 1'b1, 0};
    vc = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41};

    u.rx_data  = 8'h00;
    u.rx_ready = 1'b0;
    {adc_ch1, adc_ch2, adc_ch3, adc_ch4} = '0;
    #1 reset_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_b = 1'b1;
    @(negedge clk);

    // Single channel '2', ch2 = 2AB, fixed UART timing.
    adc_ch1 = 10'h155; adc_ch2 = 10'h2AB; adc_ch3 = 10'h0F0; adc_ch4 = 10'h3C3;
    cap.delete(); n0 = n_strobes;
    send_cmd(8'h32, err);
    check("s1_err", err, 0);
    check("s1_busy", busy, 1);
    check("s1_pre_strobe", u.tx_en, 0);
    @(negedge clk);
    check("s1_latency", u.tx_en, 1);
    check("s1_first", u.tx_data, HEADER);
    adc_ch2 = 10'h011;
    wait_idle("s1");
    check("s1_ready_at_end", u.tx_ready, 1);
    exp_q = '{8'hA5, 8'h02, 8'h02, 8'hAB};
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(8'h0E);
`endif
    compare_frame("s1");
    check("s1_strobes", n_strobes - n0, 4 + CK);

    // Command decode table.
    adc_ch1 = 10'h123; adc_ch2 = 10'h3FE; adc_ch3 = 10'h081; adc_ch4 = 10'h200;
    for (int i = 0; i < 12; i++) begin
      cap.delete(); n0 = n_strobes;
      model_frame(vecs[i].cmd, adc_ch1, adc_ch2, adc_ch3, adc_ch4);
      send_cmd(vecs[i].cmd, err);
      check($sformatf("tbl%0d_err", i), err, vecs[i].exp_err);
      if (vecs[i].exp_len > 0) begin
        wait_idle($sformatf("tbl%0d", i));
        compare_frame($sformatf("tbl%0d", i));
      end else begin
        repeat (4) @(negedge clk);
        check($sformatf("tbl%0d_busy", i), busy, 0);
      end
      check($sformatf("tbl%0d_strobes", i), n_strobes - n0, vecs[i].exp_len);
    end

    // All channels with ADC change and an overlapping command mid-frame.
    adc_ch1 = 10'h001; adc_ch2 = 10'h3FF; adc_ch3 = 10'h200; adc_ch4 = 10'h155;
    cap.delete(); n0 = n_strobes;
    send_cmd(8'h41, err);
    check("s2_err", err, 0);
    repeat (8) @(negedge clk);
    adc_ch1 = 10'h2EE; adc_ch2 = 10'h000; adc_ch3 = 10'h1D1; adc_ch4 = 10'h0AA;
    send_cmd(8'h33, err);
    check("s2_overlap_err", err, 1);
    @(negedge clk);
    check("s2_err_width", cmd_err, 0);
    wait_idle("s2");
    exp_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'hFF,
              8'h03, 8'h02, 8'h00, 8'h04, 8'h01, 8'h55};
`ifdef FRAME_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
    end
`endif
    compare_frame("s2");
    check("s2_strobes", n_strobes - n0, 13 + CK);

    // Ack timeout: the UART never drops tx_ready.
    stuck = 1'b1;
    cap.delete(); n0 = n_strobes;
    send_cmd(8'h31, err);
    k = 0;
    while (!u.tx_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("to_strobe_seen", u.tx_en, 1);
    k = 0;
    while (!tx_timeout && k < int'(ACK_TIMEOUT) + 50) begin
      @(negedge clk);
      k++;
    end
    check("to_flag", tx_timeout, 1);
    check("to_cycles", k, ACK_TIMEOUT);
    check("to_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("to_strobes", n_strobes - n0, 1);
    check("to_sticky", tx_timeout, 1);
    stuck = 1'b0;
    cap.delete(); n0 = n_strobes;
    model_frame(8'h34, adc_ch1, adc_ch2, adc_ch3, adc_ch4);
    send_cmd(8'h34, err);
    check("to_next_err", err, 0);
    check("to_cleared", tx_timeout, 0);
    wait_idle("to_next");
    compare_frame("to_next");

    // Asynchronous reset during WAIT_DONE of the third byte.
    adc_ch2 = 10'h2AB;
    cap.delete(); n0 = n_strobes;
    send_cmd(8'h32, err);
    k = 0;
    while (!((n_strobes - n0) >= 3 && !u.tx_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_reached", n_strobes - n0, 3);
    @(negedge clk);
    #2 reset_b = 1'b0;
    #1 check_reset_values("rst_async");
    repeat (3) @(negedge clk);
    check("rst_no_strobes", n_strobes - n0, 3);
    reset_b = 1'b1;
    k = 0;
    while (!u.tx_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    cap.delete(); n0 = n_strobes;
    model_frame(8'h31, adc_ch1, adc_ch2, adc_ch3, adc_ch4);
    send_cmd(8'h31, err);
    check("rst_fresh_err", err, 0);
    wait_idle("rst_fresh");
    compare_frame("rst_fresh");
    check("rst_fresh_strobes", n_strobes - n0, 4 + CK);

    // Randomized commands, ADC values, UART timing and mid-frame traffic.
    rnd_uart = 1'b1;
    for (int it = 0; it < 40; it++) begin
      c = ($urandom_range(0, 9) < 8) ? vc[$urandom_range(0, 4)] : 8'($urandom);
      adc_ch1 = 10'($urandom); adc_ch2 = 10'($urandom);
      adc_ch3 = 10'($urandom); adc_ch4 = 10'($urandom);
      cap.delete(); n0 = n_strobes;
      model_frame(c, adc_ch1, adc_ch2, adc_ch3, adc_ch4);
      send_cmd(c, err);
      check($sformatf("rnd%0d_err", it), err, !is_valid(c));
      if (is_valid(c)) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 4)) @(negedge clk);
          adc_ch1 = 10'($urandom); adc_ch3 = 10'($urandom);
          send_cmd(8'($urandom), err);
          check($sformatf("rnd%0d_busy_err", it), err, 1);
        end
        adc_ch2 = 10'($urandom); adc_ch4 = 10'($urandom);
        wait_idle($sformatf("rnd%0d", it));
        compare_frame($sformatf("rnd%0d", it));
      end else begin
        repeat (3) @(negedge clk);
        check($sformatf("rnd%0d_busy", it), busy, 0);
        check($sformatf("rnd%0d_strobes", it), n_strobes - n0, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
